// File: rtl/led_pkg.sv
// led_pkg: shared constants for the LED PWM controller.
//   LED_ADDR_*      word register indices on the I/O bus
//   LED_PERIOD_RST  reset value of the BLINK_PERIOD register
package led_pkg;

  localparam logic [1:0] LED_ADDR_ON     = 2'd0;
  localparam logic [1:0] LED_ADDR_BLINK  = 2'd1;
  localparam logic [1:0] LED_ADDR_DUTY   = 2'd2;
  localparam logic [1:0] LED_ADDR_PERIOD = 2'd3;

  localparam int LED_PERIOD_RST = 63;

endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler plus free-running PWM counter.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   pwm_cnt      current PWM position, 0 .. 2^PWM_BITS-1, wraps silently
//   tick         one-cycle pulse every PRESCALE clocks (constant 1 when PRESCALE=1)
//   frame_end    tick on the last PWM step of a frame
module led_pwm_timebase #(
  parameter int PRESCALE = 1,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                frame_end
);

  // A one-bit prescaler is kept even for PRESCALE=1 so the width is never zero.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pre_cnt;

  assign tick      = (pre_cnt == PS_MAX);
  assign frame_end = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: memory-mapped LED controller with global PWM brightness,
// per-LED blink and a programmable blink period.
// Build option: define LED_FADE_EN to make the active duty step by one per
// frame toward the written DUTY instead of jumping to it.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   sel          block select; strobes are ignored while low
//   addr         word register index (0 ON, 1 BLINK, 2 DUTY, 3 BLINK_PERIOD)
//   rstrb        read strobe, accepted with no side effects
//   wstrb        write strobe
//   wdata        write data, upper unused bits ignored
//   rdata        combinational read data, zero when sel is low
//   LED          registered active-high LED pins
// Bus handshake: there is no stall; a write is accepted on every clk edge where
// sel && wstrb is high, and rdata is valid in the same cycle sel/addr are held.
module led_pwm_driver import led_pkg::*; #(
  parameter int NUM_LEDS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1,
  parameter int BLINK_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sel,
  input  logic [1:0]          addr,
  input  logic                rstrb,
  input  logic                wstrb,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] LED
);

  logic [NUM_LEDS-1:0]   on_reg;
  logic [NUM_LEDS-1:0]   blink_reg;
  logic [PWM_BITS-1:0]   duty_shadow;
  logic [PWM_BITS-1:0]   duty_act;
  logic [BLINK_BITS-1:0] period_reg;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  phase;

  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick;
  logic                  frame_end;
  logic                  wr;
  logic                  pwm_on;

  led_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk       (clk),
    .resetn    (resetn),
    .pwm_cnt   (pwm_cnt),
    .tick      (tick),
    .frame_end (frame_end)
  );

  assign wr = sel && wstrb;

  // Full duty is forced on so the default setting behaves like a plain latch.
  assign pwm_on = (duty_act == '1) ? 1'b1 : (pwm_cnt < duty_act);

  // Bus registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      on_reg      <= '0;
      blink_reg   <= '0;
      duty_shadow <= '1;
      period_reg  <= BLINK_BITS'(LED_PERIOD_RST);
    end else if (wr) begin
      case (addr)
        LED_ADDR_ON:     on_reg      <= wdata[NUM_LEDS-1:0];
        LED_ADDR_BLINK:  blink_reg   <= wdata[NUM_LEDS-1:0];
        LED_ADDR_DUTY:   duty_shadow <= wdata[PWM_BITS-1:0];
        default:         period_reg  <= wdata[BLINK_BITS-1:0];
      endcase
    end
  end

  // Active duty only changes at a frame boundary, so a frame is never cut
  // short. A DUTY write on the same edge is seen at the following boundary.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty_act <= '1;
    end else if (frame_end) begin
`ifdef LED_FADE_EN
      if (duty_act < duty_shadow)      duty_act <= duty_act + 1'b1;
      else if (duty_act > duty_shadow) duty_act <= duty_act - 1'b1;
`else
      duty_act <= duty_shadow;
`endif
    end
  end

  // Blink phase: toggles every BLINK_PERIOD+1 frames. A period write restarts
  // the sequence in the visible phase and wins over a coincident toggle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr && (addr == LED_ADDR_PERIOD)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == period_reg) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) LED <= '0;
    else         LED <= on_reg & {NUM_LEDS{pwm_on}} & (~blink_reg | {NUM_LEDS{phase}});
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        LED_ADDR_ON:    rdata = 32'(on_reg);
        LED_ADDR_BLINK: rdata = 32'(blink_reg);
        LED_ADDR_DUTY:  rdata = 32'(duty_shadow);
        default:        rdata = 32'(period_reg);
      endcase
    end
  end

  // Inputs that carry no state: the read strobe, tick, and unused wdata bits.
  logic unused;
  assign unused = &{1'b0, rstrb, tick, wdata};

endmodule
